result_serializer: RTL

//  Transmit side of the strobed result-readout interface. It accepts one 2x2 result tile
//  (four accumulators) through a valid/ready handshake. It then drives the tile onto a

---
 rtl/result_ser_pkg.sv | 36 +++
 rtl/ser_sat_conv.sv | 22 ++
 rtl/result_serializer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/result_ser_pkg.sv
// Shared types and helpers for the result serializer.
// Holds the FSM state enum, element index constants and the saturating converter.
// Optional feature macro: SAT_EN (enables sat_conv, unsigned saturation).
package result_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    GAPW
  } ser_state_e;

  // Element order on the bus: row-major d00, d01, d10, d11.
  localparam logic [1:0] IDX_00 = 2'd0;
  localparam logic [1:0] IDX_01 = 2'd1;
  localparam logic [1:0] IDX_10 = 2'd2;
  localparam logic [1:0] IDX_11 = 2'd3;

  // Gap counter width covers GAP values 0..15.
  localparam int GAP_CNT_W = 4;

`ifdef SAT_EN
  // Conversion is done at a fixed wide width so one function serves any
  // ACC_W/DATA_W pair below 64 bits; callers cast in and out.
  localparam int CONV_W = 64;

  function automatic logic [CONV_W-1:0] sat_conv(input logic [CONV_W-1:0] x,
                                                 input int data_w);
    logic [CONV_W-1:0] max_v;
    max_v = (CONV_W'(1) << data_w) - CONV_W'(1);
    return (x > max_v) ? max_v : x;
  endfunction
`endif

endpackage

// File: rtl/ser_sat_conv.sv
// Accumulator-to-bus width conversion (purely combinational).
// Latency: 0 cycles. Backpressure: none, follows its input every cycle.
// Ports: x = ACC_W unsigned accumulator, y = DATA_W bus value.
// Macro SAT_EN: defined -> unsigned saturate to 2^DATA_W-1; undefined -> truncate.
module ser_sat_conv
  import result_ser_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic [ACC_W-1:0]  x,
  output logic [DATA_W-1:0] y
);

`ifdef SAT_EN
  assign y = DATA_W'(sat_conv(CONV_W'(x), DATA_W));
`else
  // Plain truncation: upper accumulator bits are dropped, values wrap.
  assign y = DATA_W'(x);
`endif

endmodule

// File: rtl/result_serializer.sv
// Serializes one 2x2 accumulator tile onto a DATA_W bus with per-element capture strobes.
// Latency: element k is set up A+1+k*(3+GAP) cycles after accept cycle A; one tile per 1+4*(3+GAP) cycles.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, producer holds its tile.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + in_d00..in_d11 tile input;
//   out bus, c00/c01/c10/c11 one-hot strobes, busy, done pulse, cnt_start/cnt_end timestamps.
// Macro SAT_EN selects saturating (defined) or truncating (undefined) width conversion.
module result_serializer
  import result_ser_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int DATA_W = 8,
  parameter int GAP    = 0,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  in_d00,
  input  logic [ACC_W-1:0]  in_d01,
  input  logic [ACC_W-1:0]  in_d10,
  input  logic [ACC_W-1:0]  in_d11,
  output logic [DATA_W-1:0] out,
  output logic              c00,
  output logic              c01,
  output logic              c10,
  output logic              c11,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cnt_start,
  output logic [CNT_W-1:0]  cnt_end
);

  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  ser_state_e             state, state_n;
  logic [1:0]             idx, idx_n;
  logic [GAP_CNT_W-1:0]   gap_cnt, gap_cnt_n;
  logic [ACC_W-1:0]       tile [4];
  logic [ACC_W-1:0]       mux_sel;
  logic [DATA_W-1:0]      conv_val;
  logic [CNT_W-1:0]       cnt_sys;
  logic                   accept;

  assign accept = in_valid && (state == IDLE);

  // Next-state logic. Each element walks SETUP -> STROBE -> HOLD -> GAP cycles;
  // after the last element the FSM returns to IDLE for one accept cycle.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    gap_cnt_n = gap_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = SETUP;
          idx_n   = IDX_00;
        end
      end
      SETUP:  state_n = STROBE;
      STROBE: state_n = HOLD;
      HOLD: begin
        if (GAP > 0) begin
          state_n   = GAPW;
          gap_cnt_n = GAP_LAST;
        end else if (idx == IDX_11) begin
          state_n = IDLE;
        end else begin
          state_n = SETUP;
          idx_n   = idx + 2'd1;
        end
      end
      GAPW: begin
        if (gap_cnt != '0) begin
          gap_cnt_n = gap_cnt - GAP_CNT_W'(1);
        end else if (idx == IDX_11) begin
          state_n = IDLE;
        end else begin
          state_n = SETUP;
          idx_n   = idx + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // On the accept edge the tile register is not loaded yet, so element 0
  // comes straight from the input port.
  always_comb begin
    mux_sel = tile[idx_n];
    if (state == IDLE) mux_sel = in_d00;
  end

  ser_sat_conv #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_conv (
    .x (mux_sel),
    .y (conv_val)
  );

  // Tile storage needs no reset: it is only read after a fresh accept.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      tile[0] <= in_d00;
      tile[1] <= in_d01;
      tile[2] <= in_d10;
      tile[3] <= in_d11;
    end
  end

  // All outputs are registered from the next-state decode so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= IDX_00;
      gap_cnt   <= '0;
      cnt_sys   <= '0;
      cnt_start <= '0;
      cnt_end   <= '0;
      out       <= '0;
      c00       <= 1'b0;
      c01       <= 1'b0;
      c10       <= 1'b0;
      c11       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      gap_cnt  <= gap_cnt_n;
      cnt_sys  <= cnt_sys + CNT_W'(1);
      if (accept) cnt_start <= cnt_sys;
      // c11 is high in exactly the cycle whose count we want to stamp.
      if (c11) cnt_end <= cnt_sys;
      // Bus only moves on entry to SETUP, so it is stable under every strobe.
      if (state_n == SETUP) out <= conv_val;
      c00      <= (state_n == STROBE) && (idx_n == IDX_00);
      c01      <= (state_n == STROBE) && (idx_n == IDX_01);
      c10      <= (state_n == STROBE) && (idx_n == IDX_10);
      c11      <= (state_n == STROBE) && (idx_n == IDX_11);
      done     <= (state_n == HOLD) && (idx_n == IDX_11);
      busy     <= (state_n != IDLE);
      in_ready <= (state_n == IDLE);
    end
  end

endmodule
